aes_key_expand: RTL and testbench

- AES-128 key-schedule engine downstream of the register file.
- Takes the 128-bit key word the register file drives on its key output and produces round keys 0..10 in order, one per handshake.
- Feeds the round datapath through a valid/ready stream.
- Iterative: one 128-bit round-key register, updated once per accepted round key; round keys are not stored.

---
 rtl/aes_key_expand_pkg.sv | 22 ++
 rtl/aes_key_expand_sbox.sv | 29 ++
 rtl/aes_key_expand.sv | 91 +++++++++
 tb/tb_aes_key_expand.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expand_pkg.sv
// Shared definitions for the AES-128 key-schedule engine: widths, FSM encoding
// and the GF(2^8) constants used to step the round constant.
package aes_key_expand_pkg;

  localparam int unsigned W_KEY      = 128;
  localparam int unsigned NUM_ROUNDS = 10;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_sbox.sv
// AES forward S-box: 8-bit combinational lookup, shared with the SubBytes stage.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Packed ascending range so the leftmost byte of the table is entry 0.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready
// stream, holding only the current round key and round constant.
module aes_key_expand
  import aes_key_expand_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_KEY-1:0]   key_in,
  output logic               busy,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [3:0]         rk_round,
  output logic [W_KEY-1:0]   rk_data,
  output logic               done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e     state, state_nx;
  logic [7:0] rcon;
  logic       load, advance;

  logic [31:0]      w0, w1, w2, w3, rot_w3, sub_w3, t;
  logic [31:0]      w0_n, w1_n, w2_n, w3_n;
  logic [W_KEY-1:0] rk_next;

  assign {w0, w1, w2, w3} = rk_data;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.in_byte(rot_w3[31:24]), .out_byte(sub_w3[31:24]));
  aes_sbox u_sbox1 (.in_byte(rot_w3[23:16]), .out_byte(sub_w3[23:16]));
  aes_sbox u_sbox2 (.in_byte(rot_w3[15:8]),  .out_byte(sub_w3[15:8]));
  aes_sbox u_sbox3 (.in_byte(rot_w3[7:0]),   .out_byte(sub_w3[7:0]));

  assign t       = sub_w3 ^ {rcon, 24'h000000};
  assign w0_n    = w0 ^ t;
  assign w1_n    = w1 ^ w0_n;
  assign w2_n    = w2 ^ w1_n;
  assign w3_n    = w3 ^ w2_n;
  assign rk_next = {w0_n, w1_n, w2_n, w3_n};

  assign busy     = (state == EMIT);
  assign rk_valid = (state == EMIT);
  assign done     = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = EMIT;
          load     = 1'b1;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (rk_round == LAST_ROUND) state_nx = FINISH;
          else                        advance  = 1'b1;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Round key 10 stays on rk_data after completion until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_data  <= '0;
      rk_round <= '0;
      rcon     <= RCON_INIT;
    end else if (load) begin
      rk_data  <= key_in;
      rk_round <= '0;
      rcon     <= RCON_INIT;
    end else if (advance) begin
      rk_data  <= rk_next;
      rk_round <= rk_round + 4'd1;
      rcon     <= xtime(rcon);
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;
  logic         done;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT_KEY  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [11];

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_round (rk_round),
    .rk_data  (rk_data),
    .done     (done)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, rk_valid, done} !== 3'b000 || rk_data !== '0 || rk_round !== 4'd0) begin
        failures++;
        $display("FAIL reset_hold: busy=%b valid=%b done=%b round=%0d data=%h, required all zero",
                 busy, rk_valid, done, rk_round, rk_data);
      end
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({busy, rk_valid, done} !== 3'b000 || rk_data !== '0 || rk_round !== 4'd0) begin
        failures++;
        $display("FAIL reset_idle: busy=%b valid=%b done=%b round=%0d data=%h, required all zero",
                 busy, rk_valid, done, rk_round, rk_data);
      end
    end
  endtask

  task automatic test_fips();
    int busy_cycles = 0;
    rk_ready = 1'b1;
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key_in = ALT_KEY;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(i) || rk_data !== fips_rk[i]) begin
        failures++;
        $display("FAIL fips_round%0d: valid=%b round=%0d data=%h, required valid=1 round=%0d data=%h",
                 i, rk_valid, rk_round, rk_data, i, fips_rk[i]);
      end
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fips_done: done=%b valid=%b busy=%b, required done=1 valid=0 busy=0",
               done, rk_valid, busy);
    end
    checks++;
    if (busy_cycles != 11) begin
      failures++;
      $display("FAIL fips_busy_len: got %0d cycles, required 11", busy_cycles);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rk_round !== 4'd10 || rk_data !== fips_rk[10]) begin
      failures++;
      $display("FAIL fips_after_done: done=%b round=%0d data=%h, required done=0 round=10 data=%h",
               done, rk_round, rk_data, fips_rk[10]);
    end
  endtask

  task automatic test_zero_key();
    rk_ready = 1'b1;
    key_in = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(i)) begin
        failures++;
        $display("FAIL zero_round%0d: valid=%b round=%0d, required valid=1 round=%0d",
                 i, rk_valid, rk_round, i);
      end
      if (i == 1) begin
        checks++;
        if (rk_data !== ZERO_R1) begin
          failures++;
          $display("FAIL zero_r1: got %h, required %h", rk_data, ZERO_R1);
        end
      end
      if (i == 10) begin
        checks++;
        if (rk_data !== ZERO_R10) begin
          failures++;
          $display("FAIL zero_r10: got %h, required %h", rk_data, ZERO_R10);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int idx   = 0;
    int stall = 0;
    rk_ready = 1'b0;
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && idx < 11; cyc++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(idx) || rk_data !== fips_rk[idx]) begin
        failures++;
        $display("FAIL bp_stream: valid=%b round=%0d data=%h, required valid=1 round=%0d data=%h",
                 rk_valid, rk_round, rk_data, idx, fips_rk[idx]);
      end
      if (idx == 3 && stall < 5) begin
        rk_ready = 1'b0;
        stall++;
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
      end
      if (rk_ready) idx++;
      @(negedge clk);
    end
    checks++;
    if (idx != 11 || stall != 5) begin
      failures++;
      $display("FAIL bp_complete: accepted=%0d stalls=%0d, required 11 and 5", idx, stall);
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: done=%b valid=%b, required done=1 valid=0", done, rk_valid);
    end
    rk_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored();
    rk_ready = 1'b1;
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(i) || rk_data !== fips_rk[i]) begin
        failures++;
        $display("FAIL ign_round%0d: valid=%b round=%0d data=%h, required valid=1 round=%0d data=%h",
                 i, rk_valid, rk_round, rk_data, i, fips_rk[i]);
      end
      if (i == 4) begin
        start = 1'b1; key_in = ALT_KEY;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL ign_done: done=%b, required 1", done);
    end
    start = 1'b1; key_in = ALT_KEY;
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rk_data !== fips_rk[10]) begin
      failures++;
      $display("FAIL ign_done_start: valid=%b busy=%b done=%b data=%h, required 0 0 0 data=%h",
               rk_valid, busy, done, rk_data, fips_rk[10]);
    end
    key_in = '0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_data !== '0) begin
      failures++;
      $display("FAIL ign_restart_r0: valid=%b round=%0d data=%h, required valid=1 round=0 data=0",
               rk_valid, rk_round, rk_data);
    end
    @(negedge clk);
    checks++;
    if (rk_round !== 4'd1 || rk_data !== ZERO_R1) begin
      failures++;
      $display("FAIL ign_restart_r1: round=%0d data=%h, required round=1 data=%h",
               rk_round, rk_data, ZERO_R1);
    end
    for (int c = 0; c < 20 && done !== 1'b1; c++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || rk_data !== ZERO_R10) begin
      failures++;
      $display("FAIL ign_drain: done=%b data=%h, required done=1 data=%h", done, rk_data, ZERO_R10);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rk_ready = 1'b1;
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (rk_round !== 4'd6 || rk_data !== fips_rk[6]) begin
      failures++;
      $display("FAIL rst_mid_pre: round=%0d data=%h, required round=6 data=%h",
               rk_round, rk_data, fips_rk[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rk_valid, done} !== 3'b000 || rk_data !== '0 || rk_round !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_async: busy=%b valid=%b done=%b round=%0d data=%h, required all zero",
               busy, rk_valid, done, rk_round, rk_data);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, rk_valid, done} !== 3'b000 || rk_data !== '0) begin
        failures++;
        $display("FAIL rst_mid_hold: busy=%b valid=%b done=%b data=%h, required all zero",
                 busy, rk_valid, done, rk_data);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_release: done=%b valid=%b, required 0 0", done, rk_valid);
    end
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_round !== 4'(i) || rk_data !== fips_rk[i]) begin
        failures++;
        $display("FAIL rst_mid_rerun%0d: valid=%b round=%0d data=%h, required valid=1 round=%0d data=%h",
                 i, rk_valid, rk_round, rk_data, i, fips_rk[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_done: done=%b, required 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips();
    test_zero_key();
    test_backpressure();
    test_ignored();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
